update_knn4_topk: RTL and testbench

Streaming top-K selector that sits directly downstream of the update_knn4 distance multiplier. It consumes one 32-bit unsigned distance product per handshake, plus the training label that produced it. It keeps the K smallest distances of the current query in a sorted register list. When a candidate flagged `in_last` is accepted, it dumps that list, smallest first, over a ready/valid output port for the vote stage.

---
 rtl/update_knn4_topk_if.sv | 37 +++
 rtl/update_knn4_topk.sv | 137 +++++++++++++
 tb/tb_update_knn4_topk.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/update_knn4_topk_if.sv
// rtl/update_knn4_topk_if.sv - candidate/dump stream bundle for update_knn4_topk (out_count only with UPDATE_KNN4_TOPK_CNT_EN)
interface update_knn4_topk_if #(
  parameter int DIST_WIDTH  = 32,
  parameter int LABEL_WIDTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DIST_WIDTH-1:0]  in_dist;
  logic [LABEL_WIDTH-1:0] in_label;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DIST_WIDTH-1:0]  out_dist;
  logic [LABEL_WIDTH-1:0] out_label;
  logic                   out_last;
`ifdef UPDATE_KNN4_TOPK_CNT_EN
  logic [15:0]            out_count;

  modport master (
    output in_valid, in_dist, in_label, in_last, out_ready,
    input  in_ready, out_valid, out_dist, out_label, out_last, out_count
  );
  modport slave (
    input  in_valid, in_dist, in_label, in_last, out_ready,
    output in_ready, out_valid, out_dist, out_label, out_last, out_count
  );
`else
  modport master (
    output in_valid, in_dist, in_label, in_last, out_ready,
    input  in_ready, out_valid, out_dist, out_label, out_last
  );
  modport slave (
    input  in_valid, in_dist, in_label, in_last, out_ready,
    output in_ready, out_valid, out_dist, out_label, out_last
  );
`endif
endinterface

// File: rtl/update_knn4_topk.sv
// rtl/update_knn4_topk.sv - streaming K-smallest selector with sorted dump; UPDATE_KNN4_TOPK_CNT_EN adds out_count
module update_knn4_topk #(
  parameter int K           = 3,
  parameter int DIST_WIDTH  = 32,
  parameter int LABEL_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  update_knn4_topk_if.slave  bus
);
  localparam int                    IDX_W      = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(K - 1);
  localparam logic [DIST_WIDTH-1:0] EMPTY_DIST = '1;

  typedef enum logic {ST_RUN, ST_DUMP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DIST_WIDTH-1:0]  dist_q  [K];
  logic [DIST_WIDTH-1:0]  dist_d  [K];
  logic [LABEL_WIDTH-1:0] label_q [K];
  logic [LABEL_WIDTH-1:0] label_d [K];
  logic [K-1:0]           lt;
  logic                   in_fire;
  logic                   out_fire;
`ifdef UPDATE_KNN4_TOPK_CNT_EN
  logic [15:0]            count_q, count_d;
`endif

  assign in_fire  = (state_q == ST_RUN) && bus.in_valid;
  assign out_fire = (state_q == ST_DUMP) && bus.out_ready;

  // Outputs come straight from state/slot registers through the idx mux.
  assign bus.in_ready  = (state_q == ST_RUN);
  assign bus.out_valid = (state_q == ST_DUMP);
  assign bus.out_dist  = dist_q[idx_q];
  assign bus.out_label = label_q[idx_q];
  assign bus.out_last  = (state_q == ST_DUMP) && (idx_q == IDX_LAST);
`ifdef UPDATE_KNN4_TOPK_CNT_EN
  assign bus.out_count = count_q;
`endif

  // Strict compare per slot; the list is sorted, so lt is a thermometer code and
  // an all-ones candidate never beats any slot.
  always_comb begin
    lt = '0;
    for (int i = 0; i < K; i++) lt[i] = bus.in_dist < dist_q[i];
  end

  // Next-state: clear beats everything, then insertion in RUN, then dump stepping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    for (int i = 0; i < K; i++) begin
      dist_d[i]  = dist_q[i];
      label_d[i] = label_q[i];
    end
`ifdef UPDATE_KNN4_TOPK_CNT_EN
    count_d = count_q;
`endif
    if (clear) begin
      state_d = ST_RUN;
      idx_d   = '0;
      for (int i = 0; i < K; i++) begin
        dist_d[i]  = EMPTY_DIST;
        label_d[i] = '0;
      end
`ifdef UPDATE_KNN4_TOPK_CNT_EN
      count_d = '0;
`endif
    end else if (in_fire) begin
      // Slots at/after the first winning slot shift down; the first takes the candidate.
      for (int i = K - 1; i >= 1; i--) begin
        if (lt[i]) begin
          if (lt[i-1]) begin
            dist_d[i]  = dist_q[i-1];
            label_d[i] = label_q[i-1];
          end else begin
            dist_d[i]  = bus.in_dist;
            label_d[i] = bus.in_label;
          end
        end
      end
      if (lt[0]) begin
        dist_d[0]  = bus.in_dist;
        label_d[0] = bus.in_label;
      end
`ifdef UPDATE_KNN4_TOPK_CNT_EN
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`endif
      if (bus.in_last) begin
        state_d = ST_DUMP;
        idx_d   = '0;
      end
    end else if (out_fire) begin
      if (idx_q == IDX_LAST) begin
        state_d = ST_RUN;
        idx_d   = '0;
        for (int i = 0; i < K; i++) begin
          dist_d[i]  = EMPTY_DIST;
          label_d[i] = '0;
        end
`ifdef UPDATE_KNN4_TOPK_CNT_EN
        count_d = '0;
`endif
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State, index, list and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= EMPTY_DIST;
        label_q[i] <= '0;
      end
`ifdef UPDATE_KNN4_TOPK_CNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= dist_d[i];
        label_q[i] <= label_d[i];
      end
`ifdef UPDATE_KNN4_TOPK_CNT_EN
      count_q <= count_d;
`endif
    end
  end
endmodule

// File: tb/tb_update_knn4_topk.sv
// tb/tb_update_knn4_topk.sv - self-checking bench for update_knn4_topk
module tb_update_knn4_topk;
  localparam int K  = 3;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam logic [DW-1:0] ONES = '1;
  localparam int NV = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic clear   = 1'b0;

  always #5 clk = ~clk;

  update_knn4_topk_if #(.DIST_WIDTH(DW), .LABEL_WIDTH(LW)) bus ();

  update_knn4_topk #(.K(K), .DIST_WIDTH(DW), .LABEL_WIDTH(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  typedef struct {
    int          n;
    logic [DW-1:0] d  [6];
    logic [LW-1:0] l  [6];
    logic [DW-1:0] ed [K];
    logic [LW-1:0] el [K];
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [LW-1:0] l;
  } cand_t;

  vec_t          vt [NV];
  cand_t         q [$];
  logic [DW-1:0] got_d [K];
  logic [LW-1:0] got_l [K];
  logic [DW-1:0] exp_d [K];
  logic [LW-1:0] exp_l [K];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic last);
    bus.in_valid = 1'b1;
    bus.in_dist  = d;
    bus.in_label = l;
    bus.in_last  = last;
    check("in_ready_run", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Drains K entries; entry stall_idx is held off for stall_cycles first.
  task automatic dump(input int stall_idx, input int stall_cycles);
    logic [DW-1:0] hd;
    logic [LW-1:0] hl;
    for (int i = 0; i < K; i++) begin
      check("dump_valid", bus.out_valid, 1);
      check("dump_in_ready", bus.in_ready, 0);
      check("dump_last", bus.out_last, (i == K - 1));
      if (i == stall_idx) begin
        bus.out_ready = 1'b0;
        hd = bus.out_dist;
        hl = bus.out_label;
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          check("stall_dist", bus.out_dist, hd);
          check("stall_label", bus.out_label, hl);
          check("stall_valid", bus.out_valid, 1);
          check("stall_in_ready", bus.in_ready, 0);
        end
      end
      got_d[i] = bus.out_dist;
      got_l[i] = bus.out_label;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    check("post_dump_in_ready", bus.in_ready, 1);
    check("post_dump_valid", bus.out_valid, 0);
  endtask

  // Reference: repeatedly pick the smallest (dist, arrival order) not yet taken.
  task automatic model();
    bit used [64];
    int best;
    for (int i = 0; i < 64; i++) used[i] = 1'b0;
    for (int r = 0; r < K; r++) begin
      best = -1;
      for (int i = 0; i < q.size(); i++)
        if (!used[i] && q[i].d != ONES && (best < 0 || q[i].d < q[best].d)) best = i;
      if (best < 0) begin
        exp_d[r] = ONES;
        exp_l[r] = '0;
      end else begin
        used[best] = 1'b1;
        exp_d[r] = q[best].d;
        exp_l[r] = q[best].l;
      end
    end
  endtask

  task automatic run_vec(input int v, input int stall_idx, input int stall_cycles);
    for (int c = 0; c < vt[v].n; c++) send(vt[v].d[c], vt[v].l[c], (c == vt[v].n - 1));
    check("valid_after_last", bus.out_valid, 1);
    dump(stall_idx, stall_cycles);
    for (int k = 0; k < K; k++) begin
      check("tbl_dist", got_d[k], vt[v].ed[k]);
      check("tbl_label", got_l[k], vt[v].el[k]);
    end
  endtask

  initial begin
    int n;
    cand_t x;
    bus.in_valid  = 1'b0;
    bus.in_dist   = '0;
    bus.in_label  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    vt[0].n  = 5;
    vt[0].d  = '{32'd50, 32'd20, 32'd70, 32'd10, 32'd30, 32'd0};
    vt[0].l  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    vt[0].ed = '{32'd10, 32'd20, 32'd30};
    vt[0].el = '{4'd4, 4'd2, 4'd5};
    vt[1].n  = 3;
    vt[1].d  = '{ONES, 32'd20, 32'd20, 32'd0, 32'd0, 32'd0};
    vt[1].l  = '{4'd7, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0};
    vt[1].ed = '{32'd20, 32'd20, ONES};
    vt[1].el = '{4'd1, 4'd2, 4'd0};
    vt[2].n  = 1;
    vt[2].d  = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vt[2].l  = '{4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    vt[2].ed = '{32'd5, ONES, ONES};
    vt[2].el = '{4'd9, 4'd0, 4'd0};
    vt[3].n  = 6;
    vt[3].d  = '{32'd0, 32'd7, 32'd0, 32'd7, 32'd1, 32'd0};
    vt[3].l  = '{4'd3, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    vt[3].ed = '{32'd0, 32'd0, 32'd0};
    vt[3].el = '{4'd3, 4'd2, 4'd6};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_dist", bus.out_dist, ONES);
    check("rst_out_label", bus.out_label, 0);
`ifdef UPDATE_KNN4_TOPK_CNT_EN
    check("rst_out_count", bus.out_count, 0);
`endif
    reset_n = 1'b1;
    tick();

    // Table vectors
    for (int v = 0; v < NV; v++) run_vec(v, -1, 0);

    // Reset asserted mid-stream, while dumping
    send(32'd40, 4'd1, 1'b0);
    send(32'd10, 4'd2, 1'b0);
    send(32'd5, 4'd3, 1'b1);
    check("pre_rst_valid", bus.out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_dist", bus.out_dist, ONES);
    check("mid_rst_out_label", bus.out_label, 0);
    check("mid_rst_out_last", bus.out_last, 0);
    tick();
    reset_n = 1'b1;
    tick();
    run_vec(0, -1, 0);

    // Backpressure on entry 1
    run_vec(0, 1, 4);

    // clear during DUMP idx 1 with out_ready high
    send(32'd50, 4'd1, 1'b0);
    send(32'd20, 4'd2, 1'b0);
    send(32'd30, 4'd3, 1'b1);
    check("clr_e0_dist", bus.out_dist, 20);
    bus.out_ready = 1'b1;
    tick();
    check("clr_e1_dist", bus.out_dist, 30);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.out_ready = 1'b0;
    check("clr_run_in_ready", bus.in_ready, 1);
    check("clr_run_out_valid", bus.out_valid, 0);
    check("clr_out_dist", bus.out_dist, ONES);
    send(32'd40, 4'd8, 1'b0);
    send(32'd60, 4'd9, 1'b1);
    dump(-1, 0);
    check("clr_q_d0", got_d[0], 40);
    check("clr_q_l0", got_l[0], 8);
    check("clr_q_d1", got_d[1], 60);
    check("clr_q_l1", got_l[1], 9);
    check("clr_q_d2", got_d[2], ONES);
    check("clr_q_l2", got_l[2], 0);

    // Randomized queries against the reference model
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, 10);
      q.delete();
      for (int c = 0; c < n; c++) begin
        x.d = ($urandom_range(0, 7) == 0) ? ONES : 32'($urandom_range(0, 20));
        x.l = 4'($urandom_range(0, 15));
        q.push_back(x);
        send(x.d, x.l, (c == n - 1));
      end
      model();
      dump($urandom_range(0, K), $urandom_range(0, 3));
      for (int k = 0; k < K; k++) begin
        check("rnd_dist", got_d[k], exp_d[k]);
        check("rnd_label", got_l[k], exp_l[k]);
      end
    end

`ifdef UPDATE_KNN4_TOPK_CNT_EN
    // Counter: 5 candidates, then saturation
    for (int c = 0; c < 5; c++) send(32'(c + 1), 4'd1, (c == 4));
    check("cnt_5_dump", bus.out_count, 5);
    dump(1, 2);
    check("cnt_after_dump", bus.out_count, 0);
    for (int c = 0; c < 70000; c++) send(32'd9, 4'd2, (c == 69999));
    check("cnt_sat", bus.out_count, 16'hFFFF);
    dump(-1, 0);
    check("cnt_sat_cleared", bus.out_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
